// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer geometry, word widths and the queued-write record.
package fb_arbiter_pkg;

    localparam int FB_W      = 240;
    localparam int FB_H      = 160;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int PIX_W     = 15;
    localparam int MEM_W     = 16;
    localparam int ADDR_W    = 16;

    // One pending pixel write: target word address plus RGB555 colour.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_entry_t;

    // RGB555 pixels occupy the low bits of a memory word; the top bit is zero.
    function automatic logic [MEM_W-1:0] pix_to_word(input logic [PIX_W-1:0] pix);
        return {1'b0, pix};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write queue holding pixel writes until the memory port is free.
module fb_wr_fifo
    import fb_arbiter_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wr_entry_t        push_entry,
    input  logic             pop,
    output wr_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    wr_entry_t        slot_q [DEPTH];
    wr_entry_t        slot_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slot_q[rd_ptr_q];
    assign level   = count_q;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage update: only the slot under the write pointer changes.
    always_comb begin
        slot_d = slot_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_entry;
        end
    end

    // Control state is reset; an emptied queue makes stale slot contents unreachable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win every cycle, queued pixel
// writes drain into idle cycles, out-of-range writes raise a sticky error.
module fb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_PIXELS  = fb_arbiter_pkg::FB_PIXELS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic [15:0] vga_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [14:0] wr_data,
    input  logic        err_clr,
    output logic        err_oob,
    output logic [2:0]  level,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    import fb_arbiter_pkg::*;

    localparam int              LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(FB_PIXELS);

    wr_entry_t        push_entry;
    wr_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             wr_accept;
    logic             wr_in_range;
    logic             fifo_push;
    logic             fifo_pop;

    logic             err_oob_q, err_oob_d;
    logic             rd_pend_q, rd_pend_d;
    logic [MEM_W-1:0] vga_hold_q, vga_hold_d;

    assign wr_ready    = !fifo_full && !rst;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < PIX_LIMIT);
    assign fifo_push   = wr_accept && wr_in_range;
    assign fifo_pop    = mem_we;
    assign push_entry  = '{addr: wr_addr, data: wr_data};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    assign level = 3'(fifo_level);

    // Memory port mux: scanout first, then the queue head, otherwise park at address 0.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vga_req) begin
            mem_addr = vga_addr;
        end else if (!fifo_empty && !rst) begin
            mem_addr  = head.addr;
            mem_wdata = pix_to_word(head.data);
            mem_we    = 1'b1;
        end
    end

    // Sticky error, read-pending tracker and last-delivered scanout word.
    always_comb begin
        err_oob_d = err_oob_q;
        if (err_clr) begin
            err_oob_d = 1'b0;
        end
        if (wr_accept && !wr_in_range) begin
            err_oob_d = 1'b1;
        end
        rd_pend_d  = vga_req;
        vga_hold_d = rd_pend_q ? mem_rdata : vga_hold_q;
    end

    // Register the arbiter-local state.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            vga_hold_q <= '0;
        end else begin
            err_oob_q  <= err_oob_d;
            rd_pend_q  <= rd_pend_d;
            vga_hold_q <= vga_hold_d;
        end
    end

    assign err_oob  = err_oob_q;
    assign vga_data = rd_pend_q ? mem_rdata : vga_hold_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_fb_arbiter;

    localparam int DEPTH = 4;
    localparam int NPIX  = 38400;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [15:0] vga_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [14:0] wr_data;
    logic        err_clr;
    logic        err_oob;
    logic [2:0]  level;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .FB_PIXELS  (NPIX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_clr   (err_clr),
        .err_oob   (err_oob),
        .level     (level),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t    mq[$];
    bit     m_err;
    bit     m_rdpend;
    int     m_hold;
    bit     started = 1'b0;

    // Outputs are checked at the falling edge (inputs stable since posedge+1);
    // the model then advances to the state after the coming rising edge.
    always @(negedge clk) begin
        int  e_addr, e_wdata;
        bit  e_we, e_ready;
        bit  accept;
        if (started) begin
            e_ready = !rst && (mq.size() < DEPTH);
            e_we    = 1'b0;
            e_addr  = 0;
            e_wdata = 0;
            if (vga_req) begin
                e_addr = vga_addr;
            end else if (!rst && mq.size() > 0) begin
                e_we    = 1'b1;
                e_addr  = mq[0].addr;
                e_wdata = mq[0].data;
            end
            chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, e_ready});
            chk("m_mem_we",   {31'b0, mem_we},   {31'b0, e_we});
            chk("m_mem_addr", {16'b0, mem_addr}, e_addr);
            if (e_we) chk("m_mem_wdata", {16'b0, mem_wdata}, e_wdata);
            chk("m_level",    {29'b0, level},    mq.size());
            chk("m_err_oob",  {31'b0, err_oob},  {31'b0, m_err});
            chk("m_vga_data", {16'b0, vga_data}, m_rdpend ? int'(mem_rdata) : m_hold);
        end
        if (rst) begin
            mq.delete();
            m_err    = 1'b0;
            m_rdpend = 1'b0;
            m_hold   = 0;
            started  = 1'b1;
        end else if (started) begin
            accept = wr_valid && (mq.size() < DEPTH);
            if (!vga_req && mq.size() > 0) void'(mq.pop_front());
            if (err_clr) m_err = 1'b0;
            if (accept) begin
                if (int'(wr_addr) < NPIX) mq.push_back('{addr: int'(wr_addr), data: int'(wr_data)});
                else m_err = 1'b1;
            end
            if (m_rdpend) m_hold = mem_rdata;
            m_rdpend = vga_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vga_req  = 1'b0;
        vga_addr = 16'h0;
        wr_valid = 1'b0;
        wr_addr  = 16'h0;
        wr_data  = 15'h0;
        err_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_rdata = 16'h0;
        idle();
        // Reset held: control outputs must be quiet.
        @(negedge clk);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);
        chk("rst_mem_we",   {31'b0, mem_we},   0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", {31'b0, wr_ready}, 1);
        chk("post_rst_level",    {29'b0, level},    0);
        chk("post_rst_err",      {31'b0, err_oob},  0);
        chk("post_rst_vga_data", {16'b0, vga_data}, 0);

        // Idle memory: single write drains the cycle after acceptance.
        next();
        wr_valid = 1'b1; wr_addr = 16'h0010; wr_data = 15'h7FFF;
        @(negedge clk);
        chk("idle_no_bypass", {31'b0, mem_we}, 0);
        next();
        idle();
        @(negedge clk);
        chk("idle_we",    {31'b0, mem_we},   1);
        chk("idle_addr",  {16'b0, mem_addr}, 32'h0010);
        chk("idle_wdata", {16'b0, mem_wdata}, 32'h7FFF);
        chk("idle_level1", {29'b0, level},   1);
        next();
        @(negedge clk);
        chk("idle_level0", {29'b0, level},   0);
        chk("idle_we_off", {31'b0, mem_we},  0);

        // Contention: scanout holds the port, queue fills, then drains in order.
        for (int i = 0; i < 5; i++) begin
            next();
            vga_req = 1'b1; vga_addr = 16'(i * 3);
            wr_valid = 1'b1; wr_addr = 16'(16'h0100 + i); wr_data = 15'(i + 1);
            @(negedge clk);
            chk("cont_ready", {31'b0, wr_ready}, (i < 4) ? 1 : 0);
            chk("cont_we",    {31'b0, mem_we},   0);
        end
        chk("cont_level_full", {29'b0, level}, 4);
        for (int k = 0; k < 5; k++) begin
            next();
            vga_req = 1'b0;
            if (k >= 2) wr_valid = 1'b0;
            @(negedge clk);
            chk("drain_we",    {31'b0, mem_we},    1);
            chk("drain_addr",  {16'b0, mem_addr},  32'h0100 + k);
            chk("drain_wdata", {16'b0, mem_wdata}, k + 1);
            if (k == 0) chk("drain_ready0", {31'b0, wr_ready}, 0);
            if (k == 1) chk("drain_ready1", {31'b0, wr_ready}, 1);
        end
        next();
        idle();
        @(negedge clk);
        chk("drain_done", {29'b0, level}, 0);

        // Read path: data one cycle after address, then held.
        next();
        vga_req = 1'b1; vga_addr = 16'h0123;
        @(negedge clk);
        chk("rd_addr", {16'b0, mem_addr}, 32'h0123);
        next();
        vga_req = 1'b0; mem_rdata = 16'h1234;
        @(negedge clk);
        chk("rd_data_t1", {16'b0, vga_data}, 32'h1234);
        next();
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("rd_data_t2", {16'b0, vga_data}, 32'h1234);

        // Out of range write, then clear racing a second error.
        next();
        wr_valid = 1'b1; wr_addr = 16'(NPIX); wr_data = 15'h1111;
        next();
        idle();
        @(negedge clk);
        chk("oob_err",   {31'b0, err_oob}, 1);
        chk("oob_level", {29'b0, level},   0);
        chk("oob_we",    {31'b0, mem_we},  0);
        next();
        err_clr = 1'b1; wr_valid = 1'b1; wr_addr = 16'(NPIX + 1);
        next();
        idle();
        @(negedge clk);
        chk("oob_set_wins", {31'b0, err_oob}, 1);
        next();
        err_clr = 1'b1;
        next();
        idle();
        @(negedge clk);
        chk("oob_cleared", {31'b0, err_oob}, 0);
        next();
        wr_valid = 1'b1; wr_addr = 16'(NPIX - 1); wr_data = 15'h0ABC;
        next();
        idle();
        @(negedge clk);
        chk("last_pix_we",   {31'b0, mem_we},   1);
        chk("last_pix_addr", {16'b0, mem_addr}, NPIX - 1);
        chk("last_pix_err",  {31'b0, err_oob},  0);

        // Reset mid-operation discards the queue.
        for (int i = 0; i < 3; i++) begin
            next();
            vga_req = 1'b1; wr_valid = 1'b1; wr_addr = 16'(16'h0200 + i); wr_data = 15'(i);
        end
        next();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_level3", {29'b0, level}, 3);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", {31'b0, wr_ready}, 0);
        chk("rstmid_we",    {31'b0, mem_we},   0);
        next();
        rst = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        chk("rstmid_level0", {29'b0, level},    0);
        chk("rstmid_ready1", {31'b0, wr_ready}, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_we_quiet", {31'b0, mem_we}, 0);
            next();
            @(negedge clk);
        end

        // Simultaneous push and pop at level 2.
        for (int i = 0; i < 2; i++) begin
            next();
            vga_req = 1'b1; wr_valid = 1'b1; wr_addr = 16'(16'h0300 + i); wr_data = 15'(16 + i);
        end
        next();
        vga_req = 1'b0; wr_addr = 16'h0302; wr_data = 15'd18;
        @(negedge clk);
        chk("pp_level_before", {29'b0, level},    2);
        chk("pp_head_addr",    {16'b0, mem_addr}, 32'h0300);
        next();
        idle();
        @(negedge clk);
        chk("pp_level_after", {29'b0, level},    2);
        chk("pp_next_addr",   {16'b0, mem_addr}, 32'h0301);
        repeat (3) next();

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            next();
            rst       = ($urandom_range(0, 299) == 0);
            vga_req   = ($urandom_range(0, 1) == 1);
            vga_addr  = 16'($urandom_range(0, NPIX - 1));
            wr_valid  = ($urandom_range(0, 9) < 6);
            wr_addr   = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(NPIX, 65535))
                                                     : 16'($urandom_range(0, NPIX - 1));
            wr_data   = 15'($urandom);
            err_clr   = ($urandom_range(0, 19) == 0);
            mem_rdata = 16'($urandom);
        end
        next();
        rst = 1'b0;
        idle();
        repeat (6) next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
